// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one load or store per instruction on a shared memory/IO
// bus with a req/ack handshake. Steers byte/halfword lanes on stores and
// sign/zero-extends loads. Holds stall to the fetch unit while an access is in flight.
//
// Optional feature: define BUS_TIMEOUT_EN to abort an access that has gone
// WAIT_LIMIT ACCESS cycles without bus_ack. The access completes with timeout=1 and
// rdata_out=0. When the macro is undefined, ACCESS waits indefinitely and timeout is 0.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   mem_read/mem_write  load/store in execute (both high = store)
//   mem_size            00 byte, 01 half, 1x word
//   mem_unsigned        zero-extend loads
//   addr_in, wdata_in   effective address and store data
//   stall               freeze PC/register write this cycle
//   rdata_out           extended load data, valid with done, held until next done
//   done, misalign      single-cycle completion / misaligned-reject pulses
//   timeout             pulses with done when the bus never acked
//   bus_*               request, write enable, word address, byte enables, write data
//   io_sel              request targets the IO region
//   bus_rdata, bus_ack  read data and single-cycle completion from the bus
module mem_access_ctrl #(
  parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
  parameter logic [31:0] IO_MASK    = 32'hFFFFFC00,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        io_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;

  logic        req_now;
  logic        misaligned_now;
  logic        start;
  logic [3:0]  be_now;
  logic [31:0] wdata_now;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic        limit_hit;

  always_comb begin
    req_now        = mem_read | mem_write;
    misaligned_now = ((mem_size == 2'b01) & addr_in[0]) |
                     (mem_size[1] & (addr_in[1:0] != 2'b00));
    start          = req_now & ~misaligned_now;
    stall          = (state_q == StAccess) | ((state_q == StIdle) & start);

    // Stores replicate the narrow datum across all lanes; byte enables pick the target.
    be_now    = 4'b1111;
    wdata_now = wdata_in;
    case (mem_size)
      2'b00: begin
        be_now    = 4'b0001 << addr_in[1:0];
        wdata_now = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_now    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_now = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extension uses the latched size/offset so bus_rdata can be captured on ack.
  always_comb begin
    case (addr_lo_q)
      2'b00:   lane_byte = bus_rdata[7:0];
      2'b01:   lane_byte = bus_rdata[15:8];
      2'b10:   lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
    lane_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_data = {{16{~unsigned_q & lane_half[15]}}, lane_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_lo_q  <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      io_sel     <= 1'b0;
      rdata_out  <= '0;
      done       <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StAccess;
            bus_req    <= 1'b1;
            bus_we     <= mem_write;
            bus_addr   <= {addr_in[31:2], 2'b00};
            bus_be     <= be_now;
            bus_wdata  <= wdata_now;
            io_sel     <= (addr_in & IO_MASK) == IO_BASE;
            size_q     <= mem_size;
            unsigned_q <= mem_unsigned;
            addr_lo_q  <= addr_in[1:0];
          end else if (req_now) begin
            misalign <= 1'b1;
          end
        end
        StAccess: begin
          // An ack on the limit cycle takes priority over the timeout.
          if (bus_ack) begin
            state_q   <= StResp;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            rdata_out <= bus_we ? 32'h0 : load_data;
          end else if (limit_hit) begin
            state_q   <= StResp;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            rdata_out <= 32'h0;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_q;

  // Counter holds the number of ack-less ACCESS cycles already elapsed.
  assign limit_hit = (wait_cnt_q == CntW'(WAIT_LIMIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= (state_q == StAccess) & ~bus_ack & limit_hit;
      if (state_q != StAccess) begin
        wait_cnt_q <= '0;
      end else if (!bus_ack) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wait_limit;

  assign limit_hit         = 1'b0;
  assign timeout           = 1'b0;
  assign unused_wait_limit = ^WAIT_LIMIT;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam logic [31:0] IoBase    = 32'hFFFFFC00;
  localparam logic [31:0] IoMask    = 32'hFFFFFC00;
  localparam int          WaitLimit = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        stall;
  logic [31:0] rdata_out;
  logic        done;
  logic        misalign;
  logic        timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        io_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  always #5 clock = ~clock;

  mem_access_ctrl #(
    .IO_BASE    (IoBase),
    .IO_MASK    (IoMask),
    .WAIT_LIMIT (WaitLimit)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .stall        (stall),
    .rdata_out    (rdata_out),
    .done         (done),
    .misalign     (misalign),
    .timeout      (timeout),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .io_sel       (io_sel),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model expectations for the current cycle.
  logic        exp_stall = 1'b0;
  logic        exp_req   = 1'b0;
  logic        exp_we    = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_mis   = 1'b0;
  logic        exp_to    = 1'b0;
  logic        exp_io    = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rdata = '0;
  logic [3:0]  exp_be    = '0;

  // DUT values sampled during the last access, for literal checks.
  int          stall_cycles;
  logic        seen_we;
  logic        seen_io;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes_f(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic int lane_f(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes_f(sz);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes_f(sz);
    return 4'(((1 << n) - 1) << lane_f(sz, a));
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes_f(sz);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes_f(sz);
    logic [31:0] v;
    logic [31:0] mask;
    v = rd >> (8 * lane_f(sz, a));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  always @(negedge clock) begin
    check("stall", stall, exp_stall);
    check("bus_req", bus_req, exp_req);
    check("done", done, exp_done);
    check("misalign", misalign, exp_mis);
    check("timeout", timeout, exp_to);
    check("rdata_out", rdata_out, exp_rdata);
    if (exp_req) begin
      check("bus_we", bus_we, exp_we);
      check("bus_addr", bus_addr, exp_addr);
      check("bus_be", bus_be, exp_be);
      check("io_sel", io_sel, exp_io);
      if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
    end
  end

  // One instruction; ack_at is the ACCESS cycle (1-based) carrying bus_ack, 0 = never.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                        input int ack_at);
    int   n = nbytes_f(sz);
    logic timed_out = 1'b0;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr_in = a; wdata_in = wd;
    stall_cycles = 0;
    seen_we = 1'b0; seen_io = 1'b0; seen_be = '0; seen_addr = '0; seen_wdata = '0;
    if ((int'(a[1:0]) % n) != 0) begin
      exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0;
      #1 if (stall) stall_cycles++;
      @(posedge clock); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      exp_mis = 1'b1;
      @(posedge clock); #1;
      exp_mis = 1'b0;
      return;
    end
    exp_stall = 1'b1;
    #1 if (stall) stall_cycles++;
    @(posedge clock); #1;
    exp_req   = 1'b1;
    exp_we    = wr;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = be_f(sz, a);
    exp_wdata = wdata_f(sz, wd);
    exp_io    = (a & IoMask) == IoBase;
    for (int c = 1; c <= 1000; c++) begin
      bus_ack   = (c == ack_at);
      bus_rdata = bus_ack ? rdv : $urandom();
      #1 if (stall) stall_cycles++;
      if (c == 1) begin
        seen_we = bus_we; seen_io = io_sel; seen_be = bus_be;
        seen_addr = bus_addr; seen_wdata = bus_wdata;
      end
      @(posedge clock); #1;
      if (c == ack_at) break;
`ifdef BUS_TIMEOUT_EN
      if (c == WaitLimit) begin
        timed_out = 1'b1;
        break;
      end
`endif
    end
    bus_ack   = 1'b0;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_done  = 1'b1;
    exp_to    = timed_out;
    exp_rdata = (wr || timed_out) ? 32'h0 : load_f(sz, uns, a, rdv);
    // Request stays asserted through the response cycle; it must not re-trigger.
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    exp_done = 1'b0;
    exp_to   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3);
    check("lw_rdata", rdata_out, 32'h1234_5678);
    check("lw_stall_cycles", stall_cycles, 4);
    check("lw_be", seen_be, 4'b1111);

    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 1);
    check("lb_rdata", rdata_out, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 2);
    check("lbu_rdata", rdata_out, 32'h0000_0080);

    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 2);
    check("sh_we", seen_we, 1'b1);
    check("sh_be", seen_be, 4'b1100);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_addr", seen_addr, 32'h0000_0000);
    check("sh_rdata", rdata_out, 32'h0);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FC60, 32'hDEAD_BEEF, 32'h0, 1);
    check("sw_io_sel", seen_io, 1'b1);

    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1);
    check("lw_misalign_stall", stall_cycles, 0);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 1);

    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_1234, 1);
    check("lh_rdata", rdata_out, 32'hFFFF_8001);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h8001_F234, 2);
    check("lhu_rdata", rdata_out, 32'h0000_F234);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1);
    check("lsize3_rdata", rdata_out, 32'hCAFE_F00D);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1122_3344, 32'h0, 1);
    check("sb_be", seen_be, 4'b0010);
    check("sb_wdata", seen_wdata, 32'h4444_4444);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h5A5A_0FF0, 32'h1111_1111, 1);
    check("rw_is_write", seen_we, 1'b1);
    check("rw_rdata", rdata_out, 32'h0);

    // bus_ack with nothing in flight must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bus_ack = 1'b0;
    @(posedge clock); #1;

    // Reset during ACCESS: bus_req falls at once and no response follows.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'h9999_9999, 1);
    mem_read = 1'b1; mem_size = 2'b10; addr_in = 32'h0000_0040;
    exp_stall = 1'b1;
    @(posedge clock); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0040; exp_be = 4'b1111; exp_io = 1'b0;
    @(posedge clock); #1;
    #1 reset = 1'b0;
    mem_read = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = 32'h0;
    #1 check("reset_bus_req", bus_req, 1'b0);
    check("reset_rdata", rdata_out, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 2);
    check("post_reset_rdata", rdata_out, 32'h0BAD_CAFE);

`ifdef BUS_TIMEOUT_EN
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h7777_7777, 0);
    check("to_rdata", rdata_out, 32'h0);
    check("to_stall_cycles", stall_cycles, 17);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h7777_7777, 16);
    check("ack16_rdata", rdata_out, 32'h7777_7777);
    check("ack16_stall_cycles", stall_cycles, 17);
`else
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h7777_7777, 20);
    check("long_wait_rdata", rdata_out, 32'h7777_7777);
    check("long_wait_stall_cycles", stall_cycles, 21);
`endif

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits directly downstream of the execute unit. Consumes the ALU result as the effective address and the rt operand as store data, then runs one load or store on the shared memory/IO bus using a req/ack handshake.
- Adds byte and halfword lane steering and load sign/zero extension.
- Holds a stall to the fetch unit while an access is in flight, so the single-cycle datapath tolerates multi-cycle memory and IO.

Parameters:
IO_BASE, 32'hFFFFFC00, base of IO region; io_sel=1 when (addr_in & IO_MASK)==IO_BASE
IO_MASK, 32'hFFFFFC00, address mask for IO decode
WAIT_LIMIT, 16, max cycles in ACCESS before timeout (used only with BUS_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
mem_read  input  1  load instruction in execute
mem_write  input  1  store instruction in execute
mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  input  1  1 = zero-extend load (lbu/lhu)
addr_in  input  32  effective address from ALU result
wdata_in  input  32  store data (rt)
stall  output  1  1 = freeze PC/register write this cycle
rdata_out  output  32  extended load data, valid when done=1
done  output  1  one-cycle pulse: access complete
misalign  output  1  one-cycle pulse: misaligned request rejected
timeout  output  1  one-cycle pulse with done: bus never acked
bus_req  output  1  request, held until bus_ack
bus_we  output  1  1 = write
bus_addr  output  32  {addr_in[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-steered store data
io_sel  output  1  request targets IO region
bus_rdata  input  32  read data, valid when bus_ack=1
bus_ack  input  1  completion, one cycle

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE. All outputs are 0; counter and captured data are 0. bus_req drops immediately even mid-access; no response is produced for the aborted access.
- start = (mem_read|mem_write) & ~misaligned_now, where misaligned_now = (half & addr_in[0]) | (word & addr_in[1:0]!=0). If mem_read and mem_write are both high, it is a write.
- States:
  - IDLE: stall = start (combinational). On start, latch addr/we/size/unsigned/wdata and go to ACCESS. If the request is misaligned, pulse misalign for one cycle, assert no stall and no bus_req, and stay in IDLE.
  - ACCESS: bus_req=1 and all bus_* outputs are stable from latched values; stall=1. On bus_ack, capture bus_rdata and go to RESP. bus_ack in the same cycle bus_req first rises is legal. Minimum latency is 1 ACCESS cycle.
  - RESP: done=1, stall=0, bus_req=0, rdata_out valid. The CPU commits at this edge. Always returns to IDLE, even if mem_read/mem_write is still high, so there is no re-trigger. Total load latency is ack cycle + 2.
- bus_ack outside ACCESS is ignored.
- Writes: byte writes replicate wdata[7:0] to all lanes with be = 4'b0001<<addr[1:0]. Half writes replicate wdata[15:0] with be = addr[1] ? 1100 : 0011. Word writes use be = 1111. rdata_out = 0 for writes.
- Reads: select the lane by latched addr[1:0] (half by addr[1]), then sign-extend, or zero-extend if unsigned. Word loads pass through.
- rdata_out holds its value until the next RESP. done, misalign and timeout are single-cycle pulses.
- io_sel is decoded from the latched address and valid while bus_req=1.

Optional Feature:
- BUS_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. At WAIT_LIMIT cycles the block goes to RESP with timeout=1 and rdata_out=0. An ack in the same cycle as the limit wins, giving a normal completion with timeout=0.
- Not defined: ACCESS waits indefinitely, timeout is tied to 0, and no counter is built.

Test Plan:
- Word load, addr 0x00000010, bus_rdata=0x12345678, ack after 3 cycles -> stall high 4 cycles, done with rdata_out=0x12345678, bus_be=1111.
- lb at 0x00000013, bus_rdata=0x80FFFFFF -> rdata_out=0xFFFFFF80. The same access as lbu -> 0x00000080.
- sh at 0x00000002, wdata_in=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x00000000, done after ack.
- sw at 0xFFFFFC60 -> io_sel=1. lw at 0x00000006 -> misalign pulse, no bus_req, stall=0.
- reset driven low during ACCESS -> bus_req=0 immediately, state IDLE, no done. A later load completes normally.
- BUS_TIMEOUT_EN, WAIT_LIMIT=16, no ack -> done and timeout after 16 ACCESS cycles, rdata_out=0. With ack at cycle 16 -> normal completion, timeout=0.
